// File: rtl/percept_bus_pkg.sv
// Shared encodings and frame constants for the percept bus scheduler.
// PERCEPT_BUS_PARITY_EN adds an even-parity bit between data and stop.
package percept_bus_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;
    localparam logic [2:0] ST_GAP    = 3'd6;

`ifdef PERCEPT_BUS_PARITY_EN
    localparam int PARITY_LEN = 1;
`else
    localparam int PARITY_LEN = 0;
`endif

    localparam logic SERIAL_IDLE = 1'b1;

    function automatic int frame_len(input int addr_w, input int data_w);
        return 2 + PARITY_LEN + addr_w + data_w;
    endfunction

    localparam int FRAME_LEN = frame_len(3, 8);

endpackage

// File: rtl/percept_rr_arb.sv
// Combinational round-robin grant: search starts one past the last winner.
module percept_rr_arb #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [2:0]         ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [2:0]         gnt_idx
);

    int   cand;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = (int'(ptr) + 1 + off) % NUM_REQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && i == cand && req_valid[i]) begin
                    gnt[i]  = 1'b1;
                    gnt_idx = 3'(i);
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/percept_bus_sched.sv
// Round-robin scheduler serialising one start/addr/data/stop frame per grant.
// Define PERCEPT_BUS_PARITY_EN to insert an even-parity bit before stop.
module percept_bus_sched
    import percept_bus_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      serial,
    output logic                      busy,
    output logic [2:0]                grant_id,
    output logic                      frame_done
);

    localparam int MAX_AD   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int MAX_CNT  = (MAX_AD > GAP_CYCLES) ? MAX_AD : GAP_CYCLES;
    localparam int CNT_W    = $clog2(MAX_CNT + 1);
    localparam int GAP_LOAD = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         grant_id_q, grant_id_d;
    logic [ADDR_W-1:0]  addr_sr_q, addr_sr_d, addr_sel;
    logic [DATA_W-1:0]  data_sr_q, data_sr_d, data_sel;
`ifdef PERCEPT_BUS_PARITY_EN
    logic               parity_q, parity_d;
`endif
    logic [NUM_REQ-1:0] arb_gnt;
    logic [2:0]         arb_idx;
    logic               xfer;

    percept_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx)
    );

    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                addr_sel = req_addr[i*ADDR_W +: ADDR_W];
                data_sel = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE) ? arb_gnt : '0;
    assign xfer      = |req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ptr_q      <= 3'(NUM_REQ - 1);
            grant_id_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
        end
    end

    // Payload shift registers carry no reset; they are reloaded on every grant.
    always_ff @(posedge clk) begin
        addr_sr_q <= addr_sr_d;
        data_sr_q <= data_sr_d;
`ifdef PERCEPT_BUS_PARITY_EN
        parity_q  <= parity_d;
`endif
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        addr_sr_d  = addr_sr_q;
        data_sr_d  = data_sr_q;
`ifdef PERCEPT_BUS_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d    = ST_START;
                    ptr_d      = arb_idx;
                    grant_id_d = arb_idx;
                    addr_sr_d  = addr_sel;
                    data_sr_d  = data_sel;
`ifdef PERCEPT_BUS_PARITY_EN
                    parity_d   = ^{addr_sel, data_sel};
`endif
                end
            end
            ST_START: begin
                state_d = ST_ADDR;
                cnt_d   = CNT_W'(ADDR_W - 1);
            end
            ST_ADDR: begin
                addr_sr_d = addr_sr_q << 1;
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                    cnt_d   = CNT_W'(DATA_W - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                data_sr_d = data_sr_q << 1;
                if (cnt_q == '0) begin
`ifdef PERCEPT_BUS_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PARITY: state_d = ST_STOP;
            ST_STOP: begin
                if (GAP_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_W'(GAP_LOAD);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Serial is decoded from state so an async reset forces the idle level at once.
    always_comb begin
        serial = SERIAL_IDLE;
        case (state_q)
            ST_START:  serial = ~SERIAL_IDLE;
            ST_ADDR:   serial = addr_sr_q[ADDR_W-1];
            ST_DATA:   serial = data_sr_q[DATA_W-1];
`ifdef PERCEPT_BUS_PARITY_EN
            ST_PARITY: serial = parity_q;
`endif
            default:   serial = SERIAL_IDLE;
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_STOP);
    assign grant_id   = grant_id_q;

endmodule

// File: tb/tb_percept_bus_sched.sv
// Scoreboard bench for percept_bus_sched (default build plus a GAP_CYCLES=0 instance).
`timescale 1ns/1ps
module tb_percept_bus_sched;
    import percept_bus_pkg::*;

    localparam int NR  = 2;
    localparam int AW  = 3;
    localparam int DW  = 8;
    localparam int GAP = 2;
    localparam int FL  = FRAME_LEN;
    localparam int NB  = FL + GAP;

    typedef struct packed {
        logic [2:0]    id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } frame_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [NR*AW-1:0] req_addr = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic             serial, busy, frame_done;
    logic [2:0]       grant_id;

    logic             g0_valid = 1'b0;
    logic [0:0]       g0_ready;
    logic [AW-1:0]    g0_addr = 3'b110;
    logic [DW-1:0]    g0_data = 8'h3C;
    logic             g0_serial, g0_busy, g0_fd;
    logic [2:0]       g0_gid;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    percept_bus_sched #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .serial(serial), .busy(busy),
        .grant_id(grant_id), .frame_done(frame_done)
    );

    percept_bus_sched #(.NUM_REQ(1), .ADDR_W(AW), .DATA_W(DW), .GAP_CYCLES(0)) dut_g0 (
        .clk(clk), .rst(rst), .req_valid(g0_valid), .req_ready(g0_ready),
        .req_addr(g0_addr), .req_data(g0_data), .serial(g0_serial), .busy(g0_busy),
        .grant_id(g0_gid), .frame_done(g0_fd)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int model_winner(input logic [NR-1:0] v, input int p);
        for (int k = 1; k <= NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic exp_bit(input frame_t f, input int k);
        if (k == 1) return 1'b0;
        if (k <= 1 + AW) return f.addr[AW-1-(k-2)];
        if (k <= 1 + AW + DW) return f.data[DW-1-(k-2-AW)];
`ifdef PERCEPT_BUS_PARITY_EN
        if (k == 2 + AW + DW) return ^{f.addr, f.data};
`endif
        return 1'b1;
    endfunction

    // Reference model: pointer, remaining busy cycles and expected-frame queue.
    frame_t   sb_q[$];
    frame_t   nf, cur;
    int       m_ptr = NR - 1;
    int       m_busy = 0;
    int       m_w;
    logic [2:0] gid_log[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr  = NR - 1;
            m_busy = 0;
            sb_q.delete();
        end else if (m_busy > 0) begin
            m_busy--;
        end else begin
            m_w = model_winner(req_valid, m_ptr);
            if (m_w >= 0) begin
                nf.id   = 3'(m_w);
                nf.addr = req_addr[m_w*AW +: AW];
                nf.data = req_data[m_w*DW +: DW];
                sb_q.push_back(nf);
                m_ptr  = m_w;
                m_busy = NB;
            end
        end
    end

    int          k, mw2;
    logic [NR-1:0] exp_rdy;

    always @(negedge clk) begin
        if (!rst) begin
            exp_rdy = '0;
            if (m_busy == 0) begin
                mw2 = model_winner(req_valid, m_ptr);
                if (mw2 >= 0) exp_rdy[mw2] = 1'b1;
            end
            check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
            check_eq("busy", 32'(busy), 32'(m_busy > 0));
            if (m_busy == 0) begin
                check_eq("serial_idle", 32'(serial), 1);
                check_eq("frame_done_idle", 32'(frame_done), 0);
            end else begin
                k = NB + 1 - m_busy;
                if (k == 1) begin
                    check_eq("sb_nonempty", 32'(sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) cur = sb_q.pop_front();
                    check_eq("grant_id", 32'(grant_id), 32'(cur.id));
                    gid_log.push_back(grant_id);
                end
                check_eq("serial_bit", 32'(serial), 32'(exp_bit(cur, k)));
                check_eq("frame_done", 32'(frame_done), 32'(k == FL));
            end
        end
    end

    // GAP_CYCLES=0 instance: stop, one accept cycle, then the next start bit.
    int   cyc = 0;
    int   g0_last_fd = -1;
    logic g0_fd_d1 = 1'b0, g0_fd_d2 = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            g0_last_fd = -1;
            g0_fd_d1   = 1'b0;
            g0_fd_d2   = 1'b0;
        end else begin
            if (g0_fd_d1) begin
                check_eq("g0_accept_busy", 32'(g0_busy), 0);
                check_eq("g0_accept_ready", 32'(g0_ready), 1);
            end
            if (g0_fd_d2) check_eq("g0_start", 32'(g0_serial), 0);
            if (g0_fd) begin
                if (g0_last_fd >= 0) check_eq("g0_period", 32'(cyc - g0_last_fd), 14);
                g0_last_fd = cyc;
            end
            g0_fd_d2 = g0_fd_d1;
            g0_fd_d1 = g0_fd;
        end
    end

    logic [12:0] t1_bits;
    logic        seen;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_serial", 32'(serial), 1);
        check_eq("rst_ready", 32'(req_ready), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_grant_id", 32'(grant_id), 0);
        check_eq("rst_frame_done", 32'(frame_done), 0);
        check_eq("rst_g0_serial", 32'(g0_serial), 1);
        rst = 1'b0;
        g0_valid = 1'b1;

        // Single frame from requester 0
        @(posedge clk); #1;
        req_valid = 2'b01;
        req_addr[0 +: AW] = 3'b101;
        req_data[0 +: DW] = 8'hA5;
        #1 check_eq("t1_ready_same_cycle", 32'(req_ready), 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        t1_bits = '0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            t1_bits = {t1_bits[11:0], serial};
        end
`ifndef PERCEPT_BUS_PARITY_EN
        check_eq("t1_frame_bits", 32'(t1_bits), 32'(13'b0101101001011));
`endif
        repeat (6) @(posedge clk);

        // Both requesters held valid: strict rotation from a fresh reset
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        gid_log.delete();
        req_valid = 2'b11;
        req_addr  = {3'b010, 3'b101};
        req_data  = {8'h3C, 8'hA5};
        repeat (60) @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (18) @(posedge clk);
        check_eq("t2_nframes", 32'(gid_log.size()), 4);
        for (int i = 0; i < 4 && i < gid_log.size(); i++)
            check_eq("t2_rotation", 32'(gid_log[i]), 32'(i % 2));

        // Late request waits through requester 0's frame
        #1;
        req_valid = 2'b01;
        req_addr  = {3'b110, 3'b001};
        req_data  = {8'h5A, 8'h81};
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (6) @(posedge clk);
        #1 req_valid = 2'b10;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = req_ready[1];
        end
        check_eq("t3_granted", 32'(seen), 1);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (20) @(posedge clk);

        // Reset during DATA bit 4, then a clean frame with requester 0 winning
        #1;
        req_valid = 2'b01;
        req_addr  = {3'b011, 3'b100};
        req_data  = {8'h11, 8'hF0};
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (8) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("t4_serial_async", 32'(serial), 1);
        check_eq("t4_busy_async", 32'(busy), 0);
        @(posedge clk); #1 rst = 1'b0;
        req_valid = 2'b11;
        req_addr  = {3'b000, 3'b111};
        req_data  = {8'hFF, 8'hC3};
        #1 check_eq("t4_req0_wins", 32'(req_ready), 2'b01);
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (20) @(posedge clk);

        // Random traffic including requests withdrawn before ready
        for (int i = 0; i < 150; i++) begin
            #1;
            req_valid = NR'($urandom);
            req_addr  = (NR*AW)'($urandom);
            req_data  = (NR*DW)'($urandom);
            @(posedge clk);
        end
        #1 req_valid = '0;
        repeat (20) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
